// File: rtl/fft_dmem_dma.sv
// fft_dmem_dma: moves one frame of N_POINTS complex samples from data memory into the FFT core
// (LOAD), then writes the core's result stream back to data memory (STORE).
// While idle, the memory port is passed straight through to the CPU load/store path.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   start, src_base, dst_base           frame request and byte base addresses
//   busy, done                          frame in flight / one-cycle completion pulse
//   cpu_we, cpu_addr, cpu_wdata         CPU side of the memory port
//   cpu_rdata, cpu_stall                CPU read data; stall while the port is owned here
//   mem_we, mem_addr, mem_wdata         data memory port (byte address)
//   mem_rdata                           combinational memory read data
//   fft_in_valid/ready/data             sample stream to the FFT core
//   fft_out_valid/ready/data            result stream from the FFT core
//
// Build option: define FFT_DMA_BITREV_EN to fetch samples in bit-reversed index order
// (for a DIT core). Results are always stored in natural order.

`timescale 1ns/1ps

module fft_dmem_dma #(
  parameter int unsigned N_POINTS = 8,
  parameter int unsigned CNT_W    = $clog2(N_POINTS) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  output logic        busy,
  output logic        done,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        fft_in_valid,
  input  logic        fft_in_ready,
  output logic [31:0] fft_in_data,
  input  logic        fft_out_valid,
  output logic        fft_out_ready,
  input  logic [31:0] fft_out_data
);

  localparam int unsigned IDX_W = $clog2(N_POINTS);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(N_POINTS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        rd_off, wr_off;
  logic               in_hs, out_hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
    end
  end

  // Fetch index for the current read beat.
  always_comb begin
`ifdef FFT_DMA_BITREV_EN
    idx = '0;
    for (int i = 0; i < IDX_W; i++) begin
      idx[i] = rd_cnt_q[IDX_W-1-i];
    end
`else
    idx = rd_cnt_q[IDX_W-1:0];
`endif
  end

  // Byte offsets; 32-bit adds below wrap naturally.
  assign rd_off = {{(30 - IDX_W){1'b0}}, idx, 2'b00};
  assign wr_off = {{(30 - CNT_W){1'b0}}, wr_cnt_q, 2'b00};

  assign in_hs  = fft_in_valid && fft_in_ready;
  assign out_hs = fft_out_valid && fft_out_ready;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    src_d    = src_q;
    dst_d    = dst_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d    = src_base;
          dst_d    = dst_base;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (in_hs) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == LastBeat) state_d = StStore;
        end
      end
      StStore: begin
        if (out_hs) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LastBeat) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Port mux and stream outputs. Outside IDLE the CPU side sees zeros and its writes are dropped.
  always_comb begin
    busy          = (state_q != StIdle);
    cpu_stall     = (state_q != StIdle);
    done          = (state_q == StDone);
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cpu_rdata     = '0;
    fft_in_valid  = 1'b0;
    fft_in_data   = '0;
    fft_out_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
      StLoad: begin
        mem_addr     = src_q + rd_off;
        fft_in_valid = 1'b1;
        fft_in_data  = mem_rdata;
      end
      StStore: begin
        fft_out_ready = 1'b1;
        mem_addr      = dst_q + wr_off;
        mem_wdata     = fft_out_data;
        mem_we        = fft_out_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_dmem_dma.sv
// Self-checking bench for fft_dmem_dma: behavioural word memory, loopback FFT core (FIFO),
// and a reference model of the expected fetch order, addresses and stored results.

`timescale 1ns/1ps

module tb_fft_dmem_dma;

  localparam int N = 8;
  localparam int LOG2N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_base, dst_base;
  logic        busy, done;
  logic        cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fft_in_valid, fft_in_ready;
  logic [31:0] fft_in_data;
  logic        fft_out_valid, fft_out_ready;
  logic [31:0] fft_out_data;
  logic        out_en;

  int checks = 0;
  int errors = 0;

  // Behavioural models: memory, loopback core, beat logs.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] fifo [64];
  logic [31:0] in_log [1024];
  logic [31:0] addr_log [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int in_n = 0;
  int wr_n = 0;

  always #5 clk = ~clk;

  fft_dmem_dma #(.N_POINTS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_base     (src_base),
    .dst_base     (dst_base),
    .busy         (busy),
    .done         (done),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fft_in_valid (fft_in_valid),
    .fft_in_ready (fft_in_ready),
    .fft_in_data  (fft_in_data),
    .fft_out_valid(fft_out_valid),
    .fft_out_ready(fft_out_ready),
    .fft_out_data (fft_out_data)
  );

  assign mem_rdata     = mem[mem_addr[9:2]];
  assign fft_out_valid = out_en && (wr_ptr != rd_ptr);
  assign fft_out_data  = fifo[rd_ptr % 64];

  always @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (fft_in_valid && fft_in_ready) begin
        fifo[wr_ptr % 64]    <= fft_in_data;
        wr_ptr               <= wr_ptr + 1;
        in_log[in_n % 1024]   <= fft_in_data;
        addr_log[in_n % 1024] <= mem_addr;
        in_n                 <= in_n + 1;
      end
      if (fft_out_valid && fft_out_ready) rd_ptr <= rd_ptr + 1;
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wr_n               <= wr_n + 1;
      end
    end
  end

  // Sample index fetched on beat i.
  function automatic int idx_of(input int i);
`ifdef FFT_DMA_BITREV_EN
    int r = 0;
    int x = i;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
`else
    return i;
`endif
  endfunction

  function automatic logic [31:0] src_addr(input logic [31:0] src, input int i);
    return src + 32'(4 * idx_of(i));
  endfunction

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
    ref_mem[a[9:2]] = data;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  // Drives one frame; checks timing-related properties as it goes.
  task automatic run_frame(input logic [31:0] src, input logic [31:0] dst, input bit bp,
                           input bit poke_start, input bit cpu_poke,
                           output int done_cyc, output int ndone);
    bit prev_stall;
    logic [31:0] pd, pa;
    done_cyc = -1;
    ndone = 0;
    prev_stall = 0;
    pd = '0;
    pa = '0;
    @(negedge clk);
    src_base = src; dst_base = dst; start = 1'b1;
    fft_in_ready = 1'b1; out_en = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL busy_after_start: got %b want 1", busy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (fft_in_data !== pd || mem_addr !== pa) begin
          errors++;
          $display("FAIL stall_hold: data %h addr %h want data %h addr %h",
                   fft_in_data, mem_addr, pd, pa);
        end
      end
      if (done_cyc > 0 && j == done_cyc + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL busy_after_done: got %b want 0", busy);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = j;
          checks++;
          if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_with_done: got %b want 1", busy);
          end
        end
      end
      if (poke_start && j == 3) begin
        start = 1'b1; src_base = 32'h0000_0200;
      end
      if (cpu_poke) begin
        if (fft_out_ready === 1'b1) begin
          cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
          #1;
          checks++;
          if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL lockout_cpu_side: rdata %h stall %b want 0 1", cpu_rdata, cpu_stall);
          end
        end else begin
          cpu_we = 1'b0;
        end
      end
      if (bp) begin
        fft_in_ready = 1'($urandom % 2);
        out_en       = 1'($urandom % 2);
      end
      #1;
      prev_stall = fft_in_valid && !fft_in_ready;
      pd = fft_in_data;
      pa = mem_addr;
      if (done_cyc > 0 && j >= done_cyc + 4) break;
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: done never seen, want done within 400 cycles");
    end
    fft_in_ready = 1'b1; out_en = 1'b1; cpu_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h124; cpu_wdata = 32'hA5A5_5A5A;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_stall !== 1'b0 || fft_in_valid !== 1'b0 ||
        fft_out_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy %b done %b stall %b in_valid %b out_ready %b want 0",
               busy, done, cpu_stall, fft_in_valid, fft_out_ready);
    end
    checks++;
    if (mem_addr !== 32'h124 || mem_wdata !== 32'hA5A5_5A5A || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_passthrough: addr %h wdata %h we %b want 124 a5a55a5a 0",
               mem_addr, mem_wdata, mem_we);
    end
    @(negedge clk);
    reset = 1'b1;
    cpu_write(32'h124, 32'h0BAD_F00D);
    @(negedge clk);
    cpu_addr = 32'h124;
    #1;
    checks++;
    if (cpu_rdata !== 32'h0BAD_F00D || mem[73] !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL idle_cpu_rw: rdata %h mem %h want 0badf00d", cpu_rdata, mem[73]);
    end
  endtask

  task automatic test_ideal;
    int b, bw, dc, nd;
    logic [31:0] e, a, d;
    for (int i = 0; i < N; i++) cpu_write(32'(4 * i), 32'(i + 1));
    b = in_n; bw = wr_n;
    run_frame(32'h0, 32'h40, 1'b0, 1'b0, 1'b0, dc, nd);
    checks++;
    if (dc !== 17 || nd !== 1) begin
      errors++; $display("FAIL ideal_done_cycle: cycle %0d pulses %0d want 17 1", dc, nd);
    end
    for (int i = 0; i < N; i++) begin
      a = src_addr(32'h0, i); e = ref_mem[a[9:2]]; d = 32'h40 + 32'(4 * i);
      checks++;
      if (in_log[(b + i) % 1024] !== e || mem[d[9:2]] !== e) begin
        errors++;
        $display("FAIL ideal_beat%0d: in %h stored %h want %h", i, in_log[(b + i) % 1024],
                 mem[d[9:2]], e);
      end
    end
    checks++;
    if (wr_n - bw !== N) begin
      errors++; $display("FAIL ideal_write_count: got %0d want %0d", wr_n - bw, N);
    end
  endtask

  task automatic test_reset_mid_load;
    int b, dc, nd, k;
    logic [31:0] e, a;
    b = in_n;
    @(negedge clk);
    src_base = 32'h0; dst_base = 32'h40; start = 1'b1;
    k = 0;
    while (in_n - b < 3 && k < 20) begin
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    if (in_n - b < 3) begin
      checks++; errors++;
      $display("FAIL midload_wait: beats %0d want 3", in_n - b);
    end
    reset = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h3F0; cpu_wdata = 32'h1;
    #1;
    checks++;
    if (busy !== 1'b0 || fft_in_valid !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h3F0) begin
      errors++;
      $display("FAIL midload_reset: busy %b in_valid %b we %b addr %h want 0 0 1 3f0",
               busy, fft_in_valid, mem_we, mem_addr);
    end
    cpu_we = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL midload_reset_we: got %b want 0", mem_we);
    end
    @(negedge clk);
    reset = 1'b1;
    b = in_n;
    run_frame(32'h0, 32'h40, 1'b0, 1'b0, 1'b0, dc, nd);
    for (int i = 0; i < N; i++) begin
      a = src_addr(32'h0, i); e = ref_mem[a[9:2]];
      checks++;
      if (addr_log[(b + i) % 1024] !== a || in_log[(b + i) % 1024] !== e) begin
        errors++;
        $display("FAIL restart_beat%0d: addr %h data %h want %h %h", i,
                 addr_log[(b + i) % 1024], in_log[(b + i) % 1024], a, e);
      end
    end
  endtask

  task automatic test_backpressure;
    int b, bw, dc, nd;
    logic [31:0] e, a, d;
    for (int i = 0; i < N; i++) cpu_write(32'(4 * i), $urandom);
    b = in_n; bw = wr_n;
    run_frame(32'h0, 32'h40, 1'b1, 1'b0, 1'b0, dc, nd);
    for (int i = 0; i < N; i++) begin
      a = src_addr(32'h0, i); e = ref_mem[a[9:2]]; d = 32'h40 + 32'(4 * i);
      checks++;
      if (in_log[(b + i) % 1024] !== e || mem[d[9:2]] !== e) begin
        errors++;
        $display("FAIL bp_beat%0d: in %h stored %h want %h", i, in_log[(b + i) % 1024],
                 mem[d[9:2]], e);
      end
    end
    checks++;
    if (wr_n - bw !== N || nd !== 1) begin
      errors++; $display("FAIL bp_counts: writes %0d done %0d want %0d 1", wr_n - bw, nd, N);
    end
  endtask

  task automatic test_ignored_start;
    int b, dc, nd;
    logic [31:0] e, a;
    b = in_n;
    run_frame(32'h0, 32'h40, 1'b0, 1'b1, 1'b0, dc, nd);
    checks++;
    if (nd !== 1) begin
      errors++; $display("FAIL ignored_start_done: pulses %0d want 1", nd);
    end
    for (int i = 0; i < N; i++) begin
      a = src_addr(32'h0, i); e = ref_mem[a[9:2]];
      checks++;
      if (addr_log[(b + i) % 1024] !== a || in_log[(b + i) % 1024] !== e) begin
        errors++;
        $display("FAIL ignored_start_beat%0d: addr %h data %h want %h %h", i,
                 addr_log[(b + i) % 1024], in_log[(b + i) % 1024], a, e);
      end
    end
    checks++;
    if (in_n - b !== N) begin
      errors++; $display("FAIL ignored_start_beats: got %0d want %0d", in_n - b, N);
    end
  endtask

  task automatic test_cpu_lockout;
    int bw, dc, nd;
    cpu_write(32'h40, 32'h1234_5678);
    bw = wr_n;
    run_frame(32'h0, 32'h80, 1'b0, 1'b0, 1'b1, dc, nd);
    checks++;
    if (mem[16] !== 32'h1234_5678 || wr_n - bw !== N) begin
      errors++;
      $display("FAIL lockout_mem: word16 %h writes %0d want 12345678 %0d", mem[16], wr_n - bw, N);
    end
    cpu_write(32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    cpu_addr = 32'h40;
    #1;
    checks++;
    if (mem[16] !== 32'hDEAD_BEEF || cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL idle_write_lands: word16 %h rdata %h want deadbeef", mem[16], cpu_rdata);
    end
  endtask

  task automatic test_addr_wrap;
    int b, dc, nd;
    logic [31:0] e, a, d;
    for (int i = 0; i < N; i++) cpu_write(32'hFFFF_FFF8 + 32'(4 * i), $urandom);
    b = in_n;
    run_frame(32'hFFFF_FFF8, 32'h100, 1'b0, 1'b0, 1'b0, dc, nd);
    for (int i = 0; i < N; i++) begin
      a = src_addr(32'hFFFF_FFF8, i); e = ref_mem[a[9:2]]; d = 32'h100 + 32'(4 * i);
      checks++;
      if (addr_log[(b + i) % 1024] !== a || in_log[(b + i) % 1024] !== e ||
          mem[d[9:2]] !== e) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr %h data %h stored %h want %h %h", i,
                 addr_log[(b + i) % 1024], in_log[(b + i) % 1024], mem[d[9:2]], a, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; src_base = '0; dst_base = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fft_in_ready = 1'b1; out_en = 1'b1;
    repeat (2) @(posedge clk);
    test_reset;
    test_ideal;
    test_reset_mid_load;
    test_backpressure;
    test_ignored_start;
    test_cpu_lockout;
    test_addr_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
